ask_stim_sched: RTL and testbench
=================================

# ask_stim_sched

- Sequencer that drives the TX_filt_MF → RCV_filt cascade with an upsampled 4-ASK stimulus.
- Generates one symbol every SPS clocks with zero-stuffing between symbols, from either an external symbol port or an internal PRBS.
- Appends a zero-valued flush so the cascade drains.
- Issues a receive-side valid aligned to cascade latency; replaces file-driven stimulus in the cascade bench and serves as the on-chip test source.

## Interface
- SPS, 4, samples per symbol (≥2)
- LEVEL_A, 18'sd16384, inner level magnitude A (1s17; 0.125)
- IMPULSE_AMP, 18'sd131071, impulse-mode amplitude (1s17 max)
- FLUSH_LEN, 64, zero cycles after last symbol
- LATENCY, 40, cascade input-to-output latency in clocks (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a run (sampled only in IDLE)
- stop  in  1  abort run, go to flush (sampled only in RUN)
- mode  in  2  00 external symbols, 01 impulse, 10 PRBS, 11 worst-case (+3A every symbol)
- num_sym  in  16  symbols per run, latched on start
- sym_in  in  2  external symbol, sampled on cycles where sym_req=1
- sym_req  out  1  asserted the cycle before each symbol load (mode 00)
- x_out  out  18 signed  sample to TX filter x_in (1s17)
- sym_strobe  out  1  high when x_out carries a symbol (phase 0)
- sym_out  out  2  symbol currently on x_out, held between strobes
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle pulse at run end
- y_valid  out  1  high when the cascade output corresponds to a RUN-phase sample

## Operation
- FSM IDLE → RUN → FLUSH → DONE → IDLE.
- IDLE: x_out=0, and all outputs are low.
  - On start=1, latch num_sym and mode, clear phase and symbol counters, and reseed the PRBS to 9'h1FF.
  - Go to RUN; if num_sym=0, go to FLUSH instead.
- RUN: phase counter runs 0..SPS-1.
  - Phase 0: x_out=level(sym), sym_strobe=1, sym_out=sym.
  - Other phases: x_out=0.
  - After phase SPS-1 of symbol num_sym-1, go to FLUSH.
- stop=1 in RUN: go to FLUSH at the next edge; the current symbol period is truncated. stop is ignored elsewhere.
- Gray level map (1s17), held exactly: 00→−3A, 01→−A, 11→+A, 10→+3A; 3A = 3·LEVEL_A computed at elaboration.
- Impulse mode: the first phase-0 sample is IMPULSE_AMP; all later samples are 0, and sym_strobe still pulses.
- Worst-case mode: every symbol is 10 (+3A).
- PRBS mode: PRBS-9 (x^9+x^5+1) advances 2 bits per symbol; the first bit becomes the symbol MSB.
- FLUSH: x_out=0 for exactly FLUSH_LEN cycles, then DONE.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE.
- y_valid: LATENCY-deep shift register of the RUN-state indicator (phase-independent), cleared by reset only.
- Reset mid-run: all state is cleared immediately (asynchronous), x_out=0.

## Timing
- Reset values: x_out=0, sym_out=00, and all 1-bit outputs 0; FSM=IDLE.
- All outputs are registered.
- start high at edge k: first symbol appears on x_out after edge k+1.
- Symbol n appears after edge k+1+n·SPS.
- sym_req is high during the cycle before each phase-0 edge; sym_in is sampled at that phase-0 edge.
- busy rises after edge k+1 and falls after the last FLUSH cycle.
- done is high for the one cycle after busy falls.
- y_valid is busy-RUN delayed by exactly LATENCY cycles.

## Configuration
- ASK_STIM_PRBS_EN defined: the PRBS-9 generator is instantiated and mode 10 uses it.
- ASK_STIM_PRBS_EN undefined: no PRBS logic is built; mode 10 behaves identically to mode 00 (sym_in).

## Structure
- Package ask_sched_pkg holds:
  - state enum {IDLE, RUN, FLUSH, DONE}
  - mode localparams
  - Gray symbol codes
  - function sym2level(sym, LEVEL_A) returning signed [17:0]
- Sub-module prbs9_gen (clk, reset, seed_load, adv, 2-bit out), instantiated only under ASK_STIM_PRBS_EN.

## Test plan
- Worst-case, num_sym=3, SPS=4, start at edge k:
  - x_out=+49152 after edges k+1, k+5, k+9; 0 otherwise.
  - done is high exactly one cycle after 64 flush cycles.
- External, sym_in sequence 00,01,11,10:
  - x_out phase-0 values −49152, −16384, +16384, +49152.
  - sym_req one cycle before each.
- Impulse, num_sym=10: x_out=131071 for exactly one cycle, then only zeros; 10 sym_strobe pulses.
- stop asserted at phase 2 of symbol 5 of a 100-symbol run:
  - FLUSH is entered at the next edge.
  - Exactly 64 zero cycles follow, then done.
- PRBS mode, num_sym=1022: sym_out sequence of symbols 511..1021 equals symbols 0..510; restart reproduces symbol 0.
- num_sym=0 start → busy for 64 cycles, then done; asynchronous reset mid-RUN → all outputs 0 immediately, y_valid stays 0 after release.

Source files
------------

// File: rtl/ask_sched_pkg.sv
// ask_sched_pkg: shared types, mode encodings, Gray symbol codes and the
// symbol-to-level map for the 4-ASK stimulus scheduler.
package ask_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_EXT  = 2'b00;
    localparam logic [1:0] MODE_IMP  = 2'b01;
    localparam logic [1:0] MODE_PRBS = 2'b10;
    localparam logic [1:0] MODE_WC   = 2'b11;

    // Gray-coded symbols, named by the level they select
    localparam logic [1:0] SYM_M3 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b11;
    localparam logic [1:0] SYM_P3 = 2'b10;

    // 1s17 level for a symbol; 3A is formed as A + 2A so it folds to a constant
    function automatic logic signed [17:0] sym2level(input logic [1:0] sym,
                                                     input logic signed [17:0] level_a);
        logic signed [19:0] a1;
        logic signed [19:0] a3;
        logic signed [19:0] lvl;
        a1 = {{2{level_a[17]}}, level_a};
        a3 = a1 + (a1 <<< 1);
        case (sym)
            SYM_P3:  lvl = a3;
            SYM_P1:  lvl = a1;
            SYM_M1:  lvl = -a1;
            default: lvl = -a3;
        endcase
        return lvl[17:0];
    endfunction

endpackage

// File: rtl/prbs9_gen.sv
// prbs9_gen: PRBS-9 (x^9 + x^5 + 1) producing two bits per advance.
// sym[1] is the earlier bit of the pair. Reset and seed_load both seed 9'h1FF.
module prbs9_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       seed_load,
    input  logic       adv,
    output logic [1:0] sym
);

    logic [8:0] lfsr;
    logic       b0;
    logic       b1;

    // b1 is the bit the register would produce after shifting in b0
    assign b0  = lfsr[8] ^ lfsr[4];
    assign b1  = lfsr[7] ^ lfsr[3];
    assign sym = {b0, b1};

    // two-step shift per symbol
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= 9'h1FF;
        else if (seed_load)
            lfsr <= 9'h1FF;
        else if (adv)
            lfsr <= {lfsr[6:0], b0, b1};
    end

endmodule

// File: rtl/ask_stim_sched.sv
// ask_stim_sched: upsampled 4-ASK stimulus sequencer for the TX/RCV filter cascade.
// Build option: define ASK_STIM_PRBS_EN to build the PRBS-9 source for mode 10;
// without it mode 10 takes symbols from sym_in exactly like mode 00.
//
//   state | meaning
//   IDLE  | outputs low, waiting for start
//   RUN   | one symbol per SPS clocks, zeros between symbols
//   FLUSH | FLUSH_LEN zero samples so the cascade drains
//   DONE  | one-cycle done pulse, then back to IDLE
module ask_stim_sched
    import ask_sched_pkg::*;
#(
    parameter int                SPS         = 4,
    parameter logic signed [17:0] LEVEL_A     = 18'sd16384,
    parameter logic signed [17:0] IMPULSE_AMP = 18'sd131071,
    parameter int                FLUSH_LEN   = 64,
    parameter int                LATENCY     = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [15:0]        num_sym,
    input  logic [1:0]         sym_in,
    output logic               sym_req,
    output logic signed [17:0] x_out,
    output logic               sym_strobe,
    output logic [1:0]         sym_out,
    output logic               busy,
    output logic               done,
    output logic               y_valid
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_FLUSH = FLUSH;
    localparam logic [1:0] S_DONE  = DONE;

    localparam int PH_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int FL_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN + 1) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SPS - 1);
    localparam logic [FL_W-1:0] FL_START = FL_W'(FLUSH_LEN - 1);

    logic [1:0]      state;
    logic [PH_W-1:0] phase;
    logic [15:0]     sym_left;
    logic [1:0]      mode_q;
    logic [FL_W-1:0] flush_cnt;
    logic            imp_fired;
    logic [1:0]      cur_sym;
    logic            ext_start;
    logic            ext_q;
    logic            sym_end;
    logic            run_end;
    logic [LATENCY:0] yv_sr;

`ifdef ASK_STIM_PRBS_EN
    logic [1:0] prbs_sym;
    logic       prbs_seed;
    logic       prbs_adv;

    assign ext_start = (mode == MODE_EXT);
    assign ext_q     = (mode_q == MODE_EXT);
    assign prbs_seed = (state == S_IDLE) && start;
    assign prbs_adv  = (state == S_RUN) && (phase == '0) && (mode_q == MODE_PRBS);

    prbs9_gen u_prbs (
        .clk       (clk),
        .reset     (reset),
        .seed_load (prbs_seed),
        .adv       (prbs_adv),
        .sym       (prbs_sym)
    );
`else
    assign ext_start = (mode == MODE_EXT) || (mode == MODE_PRBS);
    assign ext_q     = (mode_q == MODE_EXT) || (mode_q == MODE_PRBS);
`endif

    assign sym_end = (phase == PH_LAST);
    assign run_end = sym_end && (sym_left == 16'd0);

    // symbol source for the next phase-0 sample
    always_comb begin
        cur_sym = sym_in;
        case (mode_q)
            MODE_WC:   cur_sym = SYM_P3;
`ifdef ASK_STIM_PRBS_EN
            MODE_PRBS: cur_sym = prbs_sym;
`endif
            default:   cur_sym = sym_in;
        endcase
    end

    // sequencer FSM; outputs are registered from the state being left at each edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            phase      <= '0;
            sym_left   <= '0;
            mode_q     <= MODE_EXT;
            flush_cnt  <= '0;
            imp_fired  <= 1'b0;
            sym_req    <= 1'b0;
            x_out      <= '0;
            sym_strobe <= 1'b0;
            sym_out    <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            sym_req    <= 1'b0;
            sym_strobe <= 1'b0;
            x_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    sym_out <= 2'b00;
                    if (start) begin
                        mode_q    <= mode;
                        phase     <= '0;
                        sym_left  <= num_sym - 16'd1;
                        imp_fired <= 1'b0;
                        if (num_sym == 16'd0) begin
                            state     <= S_FLUSH;
                            flush_cnt <= FL_START;
                        end else begin
                            state   <= S_RUN;
                            sym_req <= ext_start;
                        end
                    end
                end
                S_RUN: begin
                    busy <= 1'b1;
                    if (phase == '0) begin
                        sym_strobe <= 1'b1;
                        if (mode_q == MODE_IMP) begin
                            x_out     <= imp_fired ? 18'sd0 : IMPULSE_AMP;
                            imp_fired <= 1'b1;
                        end else begin
                            x_out   <= sym2level(cur_sym, LEVEL_A);
                            sym_out <= cur_sym;
                        end
                    end
                    if (stop || run_end) begin
                        state     <= S_FLUSH;
                        flush_cnt <= FL_START;
                    end else if (sym_end) begin
                        phase    <= '0;
                        sym_left <= sym_left - 16'd1;
                        sym_req  <= ext_q;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_FLUSH: begin
                    busy <= 1'b1;
                    if (flush_cnt == '0)
                        state <= S_DONE;
                    else
                        flush_cnt <= flush_cnt - FL_W'(1);
                end
                default: begin
                    done    <= 1'b1;
                    sym_out <= 2'b00;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // RUN indicator (bit 0, same timing as busy) delayed LATENCY clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            yv_sr <= '0;
        else
            yv_sr <= {yv_sr[LATENCY-1:0], (state == S_RUN)};
    end

    assign y_valid = yv_sr[LATENCY];

endmodule

// File: tb/tb_ask_stim_sched.sv
// tb_ask_stim_sched: scoreboard bench for ask_stim_sched.
module tb_ask_stim_sched;

    localparam int SPS = 4;
    localparam int FLUSH_LEN = 64;
    localparam int LAT = 40;
    localparam logic [1:0] M_EXT  = 2'b00;
    localparam logic [1:0] M_IMP  = 2'b01;
    localparam logic [1:0] M_PRBS = 2'b10;
    localparam logic [1:0] M_WC   = 2'b11;

    typedef struct {
        int         edge_n;
        int         x;
        logic [1:0] s;
        bit         chk_s;
    } sym_exp_t;

    typedef struct {
        int rise;
        int fall;
    } win_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [15:0]        num_sym = 16'd0;
    logic [1:0]         sym_in = 2'b00;
    logic               sym_req;
    logic signed [17:0] x_out;
    logic               sym_strobe;
    logic [1:0]         sym_out;
    logic               busy;
    logic               done;
    logic               y_valid;

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;
    int probe_req = 0;
    int probe_ack = 0;
    int fin_req = 0;
    int fin_ack = 0;

    sym_exp_t sym_q[$];
    int       req_q[$];
    int       done_q[$];
    win_t     busy_q[$];
    win_t     yv_q[$];

    ask_stim_sched #(
        .SPS         (SPS),
        .LEVEL_A     (18'sd16384),
        .IMPULSE_AMP (18'sd131071),
        .FLUSH_LEN   (FLUSH_LEN),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .num_sym    (num_sym),
        .sym_in     (sym_in),
        .sym_req    (sym_req),
        .x_out      (x_out),
        .sym_strobe (sym_strobe),
        .sym_out    (sym_out),
        .busy       (busy),
        .done       (done),
        .y_valid    (y_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lvl(input logic [1:0] s);
        case (s)
            2'b00:   return -49152;
            2'b01:   return -16384;
            2'b11:   return 16384;
            default: return 49152;
        endcase
    endfunction

    task automatic push_sym(input int e, input int x, input logic [1:0] s, input bit chk);
        sym_exp_t t;
        t.edge_n = e;
        t.x = x;
        t.s = s;
        t.chk_s = chk;
        sym_q.push_back(t);
    endtask

    // busy/done/y_valid windows for a run started at edge k with r RUN cycles
    task automatic push_win(input int k, input int r);
        win_t w;
        w.rise = k + 1;
        w.fall = k + r + FLUSH_LEN + 1;
        busy_q.push_back(w);
        done_q.push_back(k + r + FLUSH_LEN + 1);
        if (r > 0) begin
            w.rise = k + 1 + LAT;
            w.fall = k + r + 1 + LAT;
            yv_q.push_back(w);
        end
    endtask

    task automatic fire(input logic [1:0] m, input logic [15:0] n);
        mode = m;
        num_sym = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic ext_run(input logic [1:0] m, input logic [1:0] s0, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] s3);
        logic [1:0] seq[4];
        int k;
        seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3;
        @(negedge clk);
        k = cyc + 1;
        for (int n = 0; n < 4; n++) begin
            push_sym(k + 1 + n * SPS, lvl(seq[n]), seq[n], 1'b1);
            req_q.push_back(k + n * SPS);
        end
        push_win(k, 4 * SPS);
        sym_in = seq[0];
        fire(m, 16'd4);
        for (int n = 0; n < 4; n++) begin
            wait_until(k + n * SPS);
            sym_in = seq[n];
            @(negedge clk);
            sym_in = ~seq[n];
        end
        wait_until(k + 4 * SPS + FLUSH_LEN + 8);
    endtask

    // monitor: pops expectations whenever the DUT presents an event
    initial begin : monitor
        sym_exp_t e;
        win_t     w;
        int       t;
        logic     busy_p;
        logic     yv_p;
        logic     rst_seen;
        int       busy_rise;
        int       yv_rise;
        busy_p = 1'b0; yv_p = 1'b0; rst_seen = 1'b0; busy_rise = 0; yv_rise = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!rst_seen) begin
                    nvec++;
                    if (x_out !== 18'sd0 || sym_out !== 2'b00 ||
                        {sym_req, sym_strobe, busy, done, y_valid} !== 5'b0) begin
                        nerr++;
                        $display("FAIL reset_outputs @%0d: x=%0d sym=%b req/stb/busy/done/yv=%b, want all zero",
                                 cyc, x_out, sym_out, {sym_req, sym_strobe, busy, done, y_valid});
                    end
                end
                rst_seen = 1'b1;
                sym_q.delete(); req_q.delete(); done_q.delete(); busy_q.delete(); yv_q.delete();
                busy_p = 1'b0; yv_p = 1'b0;
            end else begin
                rst_seen = 1'b0;
                if (sym_strobe) begin
                    nvec++;
                    if (sym_q.size() == 0) begin
                        nerr++;
                        $display("FAIL strobe_unexpected @%0d: x=%0d sym=%b", cyc, x_out, sym_out);
                    end else begin
                        e = sym_q.pop_front();
                        if (cyc != e.edge_n || int'(x_out) != e.x || (e.chk_s && sym_out != e.s)) begin
                            nerr++;
                            $display("FAIL symbol: got edge %0d x=%0d sym=%b, want edge %0d x=%0d sym=%b",
                                     cyc, x_out, sym_out, e.edge_n, e.x, e.s);
                        end
                    end
                end else if (x_out != 18'sd0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL zero_stuff @%0d: x=%0d, want 0", cyc, x_out);
                end
                if (sym_req) begin
                    nvec++;
                    t = (req_q.size() == 0) ? -1 : req_q.pop_front();
                    if (t != cyc) begin
                        nerr++;
                        $display("FAIL sym_req: seen at %0d, want %0d", cyc, t);
                    end
                end
                if (done) begin
                    nvec++;
                    t = (done_q.size() == 0) ? -1 : done_q.pop_front();
                    if (t != cyc) begin
                        nerr++;
                        $display("FAIL done: seen at %0d, want %0d", cyc, t);
                    end
                end
                if (busy && !busy_p) busy_rise = cyc;
                if (!busy && busy_p) begin
                    nvec++;
                    if (busy_q.size() == 0) begin
                        nerr++;
                        $display("FAIL busy_unexpected: window %0d..%0d, want none", busy_rise, cyc);
                    end else begin
                        w = busy_q.pop_front();
                        if (w.rise != busy_rise || w.fall != cyc) begin
                            nerr++;
                            $display("FAIL busy_window: got %0d..%0d, want %0d..%0d",
                                     busy_rise, cyc, w.rise, w.fall);
                        end
                    end
                end
                busy_p = busy;
                if (y_valid && !yv_p) yv_rise = cyc;
                if (!y_valid && yv_p) begin
                    nvec++;
                    if (yv_q.size() == 0) begin
                        nerr++;
                        $display("FAIL y_valid_unexpected: window %0d..%0d, want none", yv_rise, cyc);
                    end else begin
                        w = yv_q.pop_front();
                        if (w.rise != yv_rise || w.fall != cyc) begin
                            nerr++;
                            $display("FAIL y_valid_window: got %0d..%0d, want %0d..%0d",
                                     yv_rise, cyc, w.rise, w.fall);
                        end
                    end
                end
                yv_p = y_valid;
                if (probe_ack < probe_req) begin
                    probe_ack++;
                    nvec++;
                    if (y_valid !== 1'b0 || busy !== 1'b0 || x_out !== 18'sd0) begin
                        nerr++;
                        $display("FAIL post_reset_idle: yv=%b busy=%b x=%0d, want 0 0 0", y_valid, busy, x_out);
                    end
                end
                if (fin_ack < fin_req) begin
                    fin_ack++;
                    nvec++;
                    if (sym_q.size() != 0 || req_q.size() != 0 || done_q.size() != 0 ||
                        busy_q.size() != 0 || yv_q.size() != 0 || busy_p || yv_p) begin
                        nerr++;
                        $display("FAIL leftover: sym=%0d req=%0d done=%0d busy=%0d yv=%0d open=%b%b, want all 0",
                                 sym_q.size(), req_q.size(), done_q.size(), busy_q.size(), yv_q.size(),
                                 busy_p, yv_p);
                    end
                end
            end
        end
    end

    initial begin : stim
        int         k;
        logic [8:0] lf;
        logic       b0;
        logic       b1;
        logic [1:0] s;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // stop in IDLE must do nothing
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // worst case, 3 symbols; stop in FLUSH and start in DONE are ignored
        @(negedge clk);
        k = cyc + 1;
        for (int n = 0; n < 3; n++) push_sym(k + 1 + n * SPS, 49152, 2'b10, 1'b1);
        push_win(k, 3 * SPS);
        fire(M_WC, 16'd3);
        wait_until(k + 40);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_until(k + 76);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 90);

        // external symbols walking all four levels
        ext_run(M_EXT, 2'b00, 2'b01, 2'b11, 2'b10);

        // impulse, 10 symbols
        @(negedge clk);
        k = cyc + 1;
        for (int n = 0; n < 10; n++) push_sym(k + 1 + n * SPS, (n == 0) ? 131071 : 0, 2'b00, 1'b0);
        push_win(k, 10 * SPS);
        fire(M_IMP, 16'd10);
        wait_until(k + 10 * SPS + FLUSH_LEN + 8);

        // stop at phase 2 of symbol 5 of a 100-symbol run
        @(negedge clk);
        k = cyc + 1;
        for (int n = 0; n < 6; n++) push_sym(k + 1 + n * SPS, 49152, 2'b10, 1'b1);
        push_win(k, 5 * SPS + 3);
        fire(M_WC, 16'd100);
        wait_until(k + 5 * SPS + 2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_until(k + 5 * SPS + 3 + FLUSH_LEN + 8);

        // zero-length run: flush only
        @(negedge clk);
        k = cyc + 1;
        push_win(k, 0);
        fire(M_WC, 16'd0);
        wait_until(k + FLUSH_LEN + 8);

`ifdef ASK_STIM_PRBS_EN
        // PRBS-9, two full sequence periods, then a restart from the seed
        @(negedge clk);
        k = cyc + 1;
        lf = 9'h1FF;
        for (int n = 0; n < 1022; n++) begin
            b0 = lf[8] ^ lf[4];
            lf = {lf[7:0], b0};
            b1 = lf[8] ^ lf[4];
            lf = {lf[7:0], b1};
            s = {b0, b1};
            push_sym(k + 1 + n * SPS, lvl(s), s, 1'b1);
        end
        push_win(k, 1022 * SPS);
        fire(M_PRBS, 16'd1022);
        wait_until(k + 1022 * SPS + FLUSH_LEN + 8);

        @(negedge clk);
        k = cyc + 1;
        lf = 9'h1FF;
        for (int n = 0; n < 2; n++) begin
            b0 = lf[8] ^ lf[4];
            lf = {lf[7:0], b0};
            b1 = lf[8] ^ lf[4];
            lf = {lf[7:0], b1};
            s = {b0, b1};
            push_sym(k + 1 + n * SPS, lvl(s), s, 1'b1);
        end
        push_win(k, 2 * SPS);
        fire(M_PRBS, 16'd2);
        wait_until(k + 2 * SPS + FLUSH_LEN + 8);
`else
        // without the PRBS source, mode 10 takes sym_in
        lf = 9'h000; b0 = 1'b0; b1 = 1'b0; s = 2'b00;
        ext_run(M_PRBS, 2'b10, 2'b11, 2'b01, 2'b00);
`endif

        // asynchronous reset in the middle of a run
        @(negedge clk);
        k = cyc + 1;
        for (int n = 0; n < 3; n++) push_sym(k + 1 + n * SPS, 49152, 2'b10, 1'b1);
        fire(M_WC, 16'd20);
        wait_until(k + 10);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 10) @(negedge clk);
        probe_req++;
        repeat (3) @(negedge clk);

        fin_req++;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
